// File: rtl/zmc_wb_arb.sv
// rtl/zmc_wb_arb.sv - two-master round-robin Wishbone arbiter with cycle lock
// Optional bus watchdog: define ZMC_WB_ARB_WDOG_EN.
module zmc_wb_arb #(
    parameter int ADR_W       = 16,
    parameter int DAT_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             s_reset_h,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [DAT_W-1:0] wb_dat_o,
    input  logic [DAT_W-1:0] wb_dat_i,
    input  logic             wb_ack_i,
    output logic [1:0]       gnt_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    state_t state_q, state_d;
    logic   rr_ptr_q, rr_ptr_d;
    logic   timeout;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("zmc_wb_arb: TIMEOUT_CYC must be in 1..255");
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || !rr_ptr_q)) state_d = GNT0;
                else if (m1_cyc_i)                        state_d = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i)    state_d = m1_cyc_i ? GNT1 : IDLE;
                else if (timeout) state_d = ABORT;
            end
            GNT1: begin
                if (!m1_cyc_i)    state_d = m0_cyc_i ? GNT0 : IDLE;
                else if (timeout) state_d = ABORT;
            end
            default: state_d = IDLE;
        endcase
        // Priority flips to the other master whenever a new grant begins.
        if (state_d == GNT0 && state_q != GNT0) rr_ptr_d = 1'b1;
        if (state_d == GNT1 && state_q != GNT1) rr_ptr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (s_reset_h) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_adr_o = '0;
        wb_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        gnt_o    = 2'b00;
        case (state_q)
            GNT0: begin
                wb_cyc_o = m0_cyc_i;
                wb_stb_o = m0_stb_i;
                wb_we_o  = m0_we_i;
                wb_adr_o = m0_adr_i;
                wb_dat_o = m0_dat_i;
                m0_ack_o = wb_ack_i;
                m0_dat_o = wb_dat_i;
                gnt_o    = 2'b01;
            end
            GNT1: begin
                wb_cyc_o = m1_cyc_i;
                wb_stb_o = m1_stb_i;
                wb_we_o  = m1_we_i;
                wb_adr_o = m1_adr_i;
                wb_dat_o = m1_dat_i;
                m1_ack_o = wb_ack_i;
                m1_dat_o = wb_dat_i;
                gnt_o    = 2'b10;
            end
            default: ;
        endcase
    end

`ifdef ZMC_WB_ARB_WDOG_EN
    localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_CYC);

    logic [7:0] wdog_q, wdog_d;
    logic       abort_m1_q;
    logic       cyc_held;

    assign cyc_held = (state_q == GNT0 && m0_cyc_i) || (state_q == GNT1 && m1_cyc_i);
    assign timeout  = cyc_held && !wb_ack_i && (wdog_q == TIMEOUT_V);

    always_comb begin
        wdog_d = wdog_q;
        if (!cyc_held || wb_ack_i) wdog_d = 8'd0;
        else if (wb_stb_o)         wdog_d = wdog_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (s_reset_h) begin
            wdog_q     <= 8'd0;
            abort_m1_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            if (state_d == ABORT) abort_m1_q <= (state_q == GNT1);
        end
    end

    assign m0_err_o = (state_q == ABORT) && !abort_m1_q;
    assign m1_err_o = (state_q == ABORT) &&  abort_m1_q;
`else
    assign timeout  = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif
endmodule
